// File: rtl/alu_pipe_mc.sv
// Handshaked ALU with a registered result and an iterative shift-add multiplier.
// One operation per valid/ready transfer; MUL holds in_ready low while it iterates.
module alu_pipe_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       command,
    input  logic             size,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       signal,
    output logic             busy
);

    localparam int H       = WIDTH / 2;
    localparam int MUL_CYC = H / MUL_STEP;
    localparam int CW      = $clog2(MUL_CYC) + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_SATADD = 3'd4;
    localparam logic [2:0] OP_SATSUB = 3'd5;
    localparam logic [2:0] OP_MUL    = 3'd6;
    localparam logic [2:0] OP_XOR    = 3'd7;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [CW-1:0]    cnt;

    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic             load_alu;
    logic             load_mul;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sum_m;
    logic [WIDTH-1:0] diff_m;
    logic [WIDTH-1:0] logic_r;
    logic             carry;
    logic             borrow;
    logic             sa;
    logic             sb;
    logic             ss;
    logic             ds;
    logic [WIDTH-1:0] alu_res;
    logic [1:0]       alu_sig;
    logic [WIDTH-1:0] step_sum;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (command == OP_MUL);
    assign load_alu = accept && !is_mul;
    assign load_mul = (state == MUL_DONE) && out_free;
    assign busy     = (state == MUL_RUN);

    // Half-width ops run on zero-extended low halves, so carry lands on bit H.
    always_comb begin
        mask    = size ? {WIDTH{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
        opa     = in_a & mask;
        opb     = in_b & mask;
        sum     = {1'b0, opa} + {1'b0, opb};
        diff    = opa - opb;
        sum_m   = sum[WIDTH-1:0] & mask;
        diff_m  = diff & mask;
        carry   = size ? sum[WIDTH] : sum[H];
        borrow  = opa < opb;
        sa      = size ? in_a[WIDTH-1] : in_a[H-1];
        sb      = size ? in_b[WIDTH-1] : in_b[H-1];
        ss      = size ? sum_m[WIDTH-1] : sum_m[H-1];
        ds      = size ? diff_m[WIDTH-1] : diff_m[H-1];
        logic_r = '0;
        alu_res = '0;
        alu_sig = 2'b00;
        unique case (command)
            OP_AND, OP_OR, OP_XOR: begin
                if (command == OP_AND)
                    logic_r = opa & opb;
                else if (command == OP_OR)
                    logic_r = opa | opb;
                else
                    logic_r = opa ^ opb;
                alu_res = logic_r;
                alu_sig = {logic_r == mask, logic_r == '0};
            end
            OP_ADD: begin
                alu_res = sum_m;
                alu_sig = {(sa == sb) && (ss != sa), sum_m == '0};
            end
            OP_SUB: begin
                alu_res = diff_m;
                alu_sig = {(sa != sb) && (ds != sa), diff_m == '0};
            end
            OP_SATADD: begin
                alu_res = carry ? mask : sum_m;
                alu_sig = {carry, !carry && (sum_m == '0)};
            end
            OP_SATSUB: begin
                alu_res = borrow ? '0 : diff_m;
                alu_sig = {borrow, !borrow && (diff_m == '0)};
            end
            OP_MUL: begin
                alu_res = '0;
                alu_sig = 2'b00;
            end
        endcase
    end

    always_comb begin
        step_sum = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j])
                step_sum = step_sum + (mcand << j);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state  <= MUL_RUN;
                        acc    <= '0;
                        mcand  <= {{H{1'b0}}, in_a[H-1:0]};
                        mplier <= in_b[H-1:0];
                        cnt    <= '0;
                    end
                end
                MUL_RUN: begin
                    acc    <= step_sum;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYC - 1))
                        state <= MUL_DONE;
                end
                MUL_DONE: begin
                    if (out_free)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            signal    <= 2'b00;
        end else if (load_alu) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            signal    <= alu_sig;
        end else if (load_mul) begin
            out_valid <= 1'b1;
            result    <= acc;
            signal    <= {1'b0, acc == '0};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_pipe_mc.md
Name: alu_pipe_mc

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It accepts one operation per valid/ready transfer and holds results in a skid-free output register until the consumer accepts them. The half-width multiply is replaced by an iterative shift-add engine, so MUL is multi-cycle with back-pressure. It sits between the instruction issue stage and the writeback arbiter.

Parameters:
WIDTH, 32, full operand width; must be even and >= 8; half width H = WIDTH/2
MUL_STEP, 2, multiplier bits retired per cycle; must divide H
(derived) MUL_CYC = H/MUL_STEP, multiply iteration count

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  block can accept an operation this cycle
command  input  3  opcode (0 AND, 1 OR, 2 ADD, 3 SUB, 4 SATADD, 5 SATSUB, 6 MUL, 7 XOR)
size  input  1  0 = H-bit operation, 1 = WIDTH-bit operation
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
signal  output  2  status flags for the result
busy  output  1  multiplier iterating

Behaviour:
- Reset: out_valid=0, result=0, signal=0, busy=0. The FSM goes to IDLE and the multiplier accumulator and counter clear. Reset aborts any in-flight multiply; the aborted result is never presented.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states:
  - IDLE:
    - Non-MUL accept: compute combinationally and load the output register at that edge. out_valid=1 the next cycle (latency 1).
    - MUL accept: latch operands and move to MUL_RUN.
  - MUL_RUN: busy=1. Each cycle, add the partial products of MUL_STEP multiplier bits. After MUL_CYC cycles, move to MUL_DONE.
  - MUL_DONE: wait until !out_valid || out_ready, then load the output register and return to IDLE. Total MUL latency from accept to out_valid is MUL_CYC+1 cycles when unstalled.
- Output register:
  - out_valid clears on out_ready when no new load occurs that edge.
  - A simultaneous consume and load keeps out_valid=1 with the new data.
  - result and signal are stable while out_valid && !out_ready.
- Width rules:
  - size=0 operates on bits [H-1:0] and drives result[WIDTH-1:H]=0.
  - size=1 operates on the full width.
  - MUL ignores size: it computes the unsigned in_a[H-1:0]*in_b[H-1:0] into WIDTH bits.
- Flags per opcode (zero is tested over the active width):
  - AND/OR/XOR: signal[1] = all ones; signal[0] = all zeros.
  - ADD: signal[1] = two's-complement overflow (operand signs equal, result sign differs); signal[0] = zero.
  - SUB (A-B): signal[1] = operand signs differ and result sign differs from A; signal[0] = zero.
  - SATADD (unsigned): on carry out, result = all ones of the active width and signal[1]=1; signal[0] = zero result.
  - SATSUB (unsigned): on borrow (A<B), result = 0, signal[1]=1 and signal[0]=0. Otherwise signal[0] = zero result.
  - MUL: signal[1]=0; signal[0] = product==0.
- No X is ever driven on outputs. Inputs other than in_valid are don't-care when not accepted.

Test Plan:
1. WIDTH=32, size=1, ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, signal=2'b10.
2. size=0, SATADD 0xFFFF+0x0002 with in_a[31:16]=0xABCD -> result=0x0000FFFF, signal=2'b10; SATSUB 0x0003-0x0005 -> result=0, signal=2'b10.
3. MUL 0xFFFF*0xFFFF, MUL_STEP=2 -> busy for 8 cycles, in_ready=0 throughout, out_valid 9 cycles after accept, result=0xFFFE0001, signal=2'b00; MUL 0x1234*0 -> result=0, signal=2'b01.
4. Back-pressure: out_ready=0, issue AND 0xF0F0F0F0&0x0F0F0F0F -> result=0, signal=2'b01 held; in_ready=0 until out_ready pulses. Back-to-back ops with out_ready=1 sustain one result per cycle.
5. Reset asserted on cycle 3 of MUL_RUN -> next cycle busy=0, out_valid=0, in_ready=1; no stale product appears afterwards.
6. XOR size=0 0x1234AAAA^0x99995555 -> result=0x0000FFFF, signal=2'b10. Stalled MUL_DONE with out_ready=0 for 5 cycles -> product delivered intact when out_ready rises.
